// File: rtl/i2c_target_if.sv
// -----------------------------------------------------------------------------
// i2c_target_if
// Bundles the I2C pad signals and the byte-wide register port of i2c_target.
//   slave  modport : seen by the target (bus levels and rd_data in, the rest out)
//   master modport : seen by the surrounding logic / bus model
// Signals:
//   scl_i, sda_i : bus line levels, asynchronous to the system clock
//   sda_oe       : 1 = pull SDA low, 0 = release (open-drain)
//   wr_en        : 1-clk pulse per received write data byte
//   wr_addr      : register pointer of that byte
//   wr_data      : received byte
//   rd_addr      : current register pointer for reads
//   rd_data      : user data for rd_addr
//   busy         : transfer in progress for this target
// -----------------------------------------------------------------------------
interface i2c_target_if #(
    parameter int REG_AW = 4
);
    logic              scl_i;
    logic              sda_i;
    logic              sda_oe;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [REG_AW-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              busy;

    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
    );
endinterface

// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
// I2C target that oversamples SCL/SDA on the system clock, detects START,
// repeated START and STOP, matches a 7-bit device address and exposes a
// byte-wide register port. A write carries a pointer byte followed by data
// bytes; a read returns bytes from the pointer. The single pointer
// auto-increments after every data byte and wraps modulo 2**REG_AW.
//
// Parameters:
//   DEV_ADDR : 7-bit address this target answers to
//   REG_AW   : register pointer width
// Ports:
//   clk  : system clock (12 MHz)
//   rst  : asynchronous reset, active-high
//   bus  : i2c_target_if.slave (scl_i, sda_i, sda_oe, wr_en, wr_addr,
//          wr_data, rd_addr, rd_data, busy)
// Optional build macro:
//   GLITCH_FILTER_EN : adds a 3-sample majority filter on both lines after
//                      the synchronisers (rejects pulses of 1 clk, adds
//                      2 clk of edge latency).
// -----------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         REG_AW   = 4
) (
    input  logic clk,
    input  logic rst,
    i2c_target_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, PTR, ACK_P, WR_DATA, ACK_W, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // Synchronisers reset to the idle bus level so reset release creates no edges
    logic [1:0] scl_sync, sda_sync;
    logic       scl_line, sda_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
        end
    end

`ifdef GLITCH_FILTER_EN
    // Majority of the current and two previous samples, registered
    logic [1:0] scl_hist, sda_hist;
    logic       scl_filt, sda_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_filt <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                        (scl_hist[0] & scl_hist[1]);
            sda_filt <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                        (sda_hist[0] & sda_hist[1]);
        end
    end

    assign scl_line = scl_filt;
    assign sda_line = sda_filt;
`else
    assign scl_line = scl_sync[1];
    assign sda_line = sda_sync[1];
`endif

    logic scl_prev, sda_prev;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_line;
            sda_prev <= sda_line;
        end
    end

    assign scl_rise = scl_line & ~scl_prev;
    assign scl_fall = ~scl_line & scl_prev;
    // Bus conditions qualify on the previous SCL level, so an SDA change that
    // lands in the same clk as an SCL change is judged against the old SCL.
    assign start_cond = scl_prev & sda_prev & ~sda_line;
    assign stop_cond  = scl_prev & ~sda_prev & sda_line;

    state_t            state, state_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        rx_shift, rx_shift_n;
    logic [7:0]        tx_shift, tx_shift_n;
    logic [REG_AW-1:0] ptr, ptr_n;
    logic              rw_bit, rw_bit_n;
    logic              master_nack, master_nack_n;
    logic              sda_oe_q, sda_oe_n;
    logic              busy_q, busy_n;
    logic              wr_en_q, wr_en_n;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_n;
    logic [7:0]        wr_data_q, wr_data_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            ptr         <= '0;
            rw_bit      <= 1'b0;
            master_nack <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            rx_shift    <= rx_shift_n;
            tx_shift    <= tx_shift_n;
            ptr         <= ptr_n;
            rw_bit      <= rw_bit_n;
            master_nack <= master_nack_n;
            sda_oe_q    <= sda_oe_n;
            busy_q      <= busy_n;
            wr_en_q     <= wr_en_n;
            wr_addr_q   <= wr_addr_n;
            wr_data_q   <= wr_data_n;
        end
    end

    // Bits are taken on SCL rise; every change of sda_oe and every state hop
    // at a byte/ACK boundary happens on SCL fall, so SDA is never moved while
    // SCL is high.
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        rx_shift_n    = rx_shift;
        tx_shift_n    = tx_shift;
        ptr_n         = ptr;
        rw_bit_n      = rw_bit;
        master_nack_n = master_nack;
        sda_oe_n      = sda_oe_q;
        busy_n        = busy_q;
        wr_en_n       = 1'b0;
        wr_addr_n     = wr_addr_q;
        wr_data_n     = wr_data_q;

        if (stop_cond) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_cond) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b1;
        end else begin
            case (state)
                ADDR, PTR, WR_DATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        rx_shift_n = {rx_shift[6:0], sda_line};
                        bit_cnt_n  = bit_cnt + 4'd1;
                        if (state == WR_DATA && bit_cnt == 4'd7) begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = ptr;
                            wr_data_n = {rx_shift[6:0], sda_line};
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (rx_shift[7:1] == DEV_ADDR) begin
                                state_n  = ACK_A;
                                sda_oe_n = 1'b1;
                                rw_bit_n = rx_shift[0];
                            end else begin
                                state_n = WAIT_STOP;
                                busy_n  = 1'b0;
                            end
                        end else if (state == PTR) begin
                            ptr_n    = rx_shift[REG_AW-1:0];
                            state_n  = ACK_P;
                            sda_oe_n = 1'b1;
                        end else begin
                            state_n  = ACK_W;
                            sda_oe_n = 1'b1;
                        end
                    end
                end
                ACK_A: begin
                    if (scl_fall) begin
                        if (rw_bit) begin
                            state_n    = RD_DATA;
                            tx_shift_n = bus.rd_data;
                            sda_oe_n   = ~bus.rd_data[7];
                        end else begin
                            state_n  = PTR;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                ACK_P: begin
                    if (scl_fall) begin
                        state_n  = WR_DATA;
                        sda_oe_n = 1'b0;
                    end
                end
                ACK_W: begin
                    if (scl_fall) begin
                        ptr_n    = ptr + REG_AW'(1);
                        state_n  = WR_DATA;
                        sda_oe_n = 1'b0;
                    end
                end
                RD_DATA: begin
                    // The MSB is already on the line; each fall presents the next bit
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n   = RD_ACK;
                            sda_oe_n  = 1'b0;
                            ptr_n     = ptr + REG_AW'(1);
                            bit_cnt_n = '0;
                        end else begin
                            tx_shift_n = {tx_shift[6:0], 1'b0};
                            sda_oe_n   = ~tx_shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        master_nack_n = sda_line;
                    end else if (scl_fall) begin
                        if (master_nack) begin
                            state_n = WAIT_STOP;
                        end else begin
                            state_n    = RD_DATA;
                            tx_shift_n = bus.rd_data;
                            sda_oe_n   = ~bus.rd_data[7];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sda_oe  = sda_oe_q;
    assign bus.busy    = busy_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_addr = ptr;

endmodule
